// File: rtl/op_prefix_sequencer.sv
// op_prefix_sequencer: front end of the XIX/XIY opcode-decode path.
// Accepts opcode bytes from fetch, tracks DD/FD prefix state, latches the
// opcode into Source/notSource and runs the XPT phase counter consumed by
// the decoder tree.  Displacement bytes for (IX+d)/(IY+d) are fetched on
// the decoder's request and sign-extended into Disp_Ext.
// Optional feature: define OP_PREFIX_CB_EN to enable the DD CB d op /
// FD CB d op form (CBDISP path and the Is_CB output).
module op_prefix_sequencer #(
    parameter int XPT_W      = 5,
    parameter int PREFIX_MAX = 15
) (
    input  logic             CLK,
    input  logic             notReset,
    output logic             Fetch_Req,
    input  logic             Fetch_Ack,
    input  logic [7:0]       Fetch_Data,
    input  logic             Stall,
    input  logic             Disp_Req,
    input  logic             PR_Reset_XPT,
    input  logic             P2_Reset_XIX,
    input  logic             P2_Reset_XIY,
    output logic             Decode_Enable,
    output logic             is_Y,
    output logic             XIX,
    output logic             XIY,
    output logic [XPT_W-1:0] XPT,
    output logic [XPT_W-1:0] notXPT,
    output logic [7:0]       Source,
    output logic [7:0]       notSource,
    output logic [15:0]      Disp_Ext,
    output logic             Prefix_Chain,
    output logic             Prefix_Overflow,
`ifdef OP_PREFIX_CB_EN
    output logic             XPT_Overrun,
    output logic             Is_CB
`else
    output logic             XPT_Overrun
`endif
);

    localparam logic [7:0] PFX_DD  = 8'hDD;
    localparam logic [7:0] PFX_FD  = 8'hFD;
`ifdef OP_PREFIX_CB_EN
    localparam logic [7:0] PFX_CB  = 8'hCB;
`endif
    // Counter is one wider than needed for PREFIX_MAX=255 so it can saturate above it
    localparam logic [8:0] CNT_MAX = 9'(PREFIX_MAX);
    localparam logic [8:0] CNT_SAT = 9'(PREFIX_MAX + 1);

    typedef enum logic [2:0] {
        S_FETCH,
        S_EXEC,
`ifdef OP_PREFIX_CB_EN
        S_DISP,
        S_CBDISP,
        S_CBOP
`else
        S_DISP
`endif
    } state_t;

    state_t             state_q, state_d;
    logic               freq_q, freq_d;
    logic               dec_q, dec_d;
    logic [XPT_W-1:0]   xpt_q, xpt_d;
    logic [XPT_W-1:0]   nxpt_q;
    logic [7:0]         src_q, src_d;
    logic [7:0]         nsrc_q;
    logic               xix_q, xix_d;
    logic               xiy_q, xiy_d;
    logic [15:0]        disp_q, disp_d;
    logic               chain_q, chain_d;
    logic [8:0]         cnt_q, cnt_d;
    logic               povf_q, povf_d;
    logic               ovr_q, ovr_d;
`ifdef OP_PREFIX_CB_EN
    logic               iscb_q, iscb_d;
`endif
    logic               transfer;

    // A byte only moves when we are actually asking for one
    assign transfer = freq_q & Fetch_Ack;

    // Next-state logic: prefix tracking, opcode latch, XPT sequencing, displacement capture
    always_comb begin
        state_d = state_q;
        xpt_d   = xpt_q;
        src_d   = src_q;
        xix_d   = xix_q;
        xiy_d   = xiy_q;
        disp_d  = disp_q;
        chain_d = chain_q;
        cnt_d   = cnt_q;
        povf_d  = povf_q;
        ovr_d   = ovr_q;
`ifdef OP_PREFIX_CB_EN
        iscb_d  = iscb_q;
`endif

        if (P2_Reset_XIX) begin
            xix_d = 1'b0;
        end
        if (P2_Reset_XIY) begin
            xiy_d = 1'b0;
        end

        case (state_q)
            S_FETCH: begin
                if (transfer) begin
                    if (Fetch_Data == PFX_DD || Fetch_Data == PFX_FD) begin
                        // A fresh prefix overrides both flags and any clear strobe this cycle
                        xix_d   = (Fetch_Data == PFX_DD);
                        xiy_d   = (Fetch_Data == PFX_FD);
                        chain_d = 1'b1;
                        if (cnt_q != CNT_SAT) begin
                            cnt_d = cnt_q + 9'd1;
                        end
                        if (cnt_d > CNT_MAX) begin
                            povf_d = 1'b1;
                        end
`ifdef OP_PREFIX_CB_EN
                    end else if (Fetch_Data == PFX_CB && (xix_q || xiy_q)) begin
                        iscb_d  = 1'b1;
                        state_d = S_CBDISP;
`endif
                    end else begin
                        src_d   = Fetch_Data;
                        xpt_d   = '0;
                        chain_d = 1'b0;
                        cnt_d   = '0;
                        state_d = S_EXEC;
                    end
                end
            end
            S_EXEC: begin
                if (PR_Reset_XPT) begin
                    xpt_d   = '0;
                    state_d = S_FETCH;
`ifdef OP_PREFIX_CB_EN
                    iscb_d  = 1'b0;
`endif
                end else if (xpt_q == '1) begin
                    // Runaway instruction: abort rather than wrap the phase counter
                    ovr_d   = 1'b1;
                    xpt_d   = '0;
                    xix_d   = 1'b0;
                    xiy_d   = 1'b0;
                    state_d = S_FETCH;
`ifdef OP_PREFIX_CB_EN
                    iscb_d  = 1'b0;
`endif
                end else if (Disp_Req) begin
                    state_d = S_DISP;
                end else if (!Stall) begin
                    xpt_d = xpt_q + 1'b1;
                end
            end
            S_DISP: begin
                if (transfer) begin
                    disp_d  = {{8{Fetch_Data[7]}}, Fetch_Data};
                    xpt_d   = xpt_q + 1'b1;
                    state_d = S_EXEC;
                end
            end
`ifdef OP_PREFIX_CB_EN
            S_CBDISP: begin
                if (transfer) begin
                    disp_d  = {{8{Fetch_Data[7]}}, Fetch_Data};
                    state_d = S_CBOP;
                end
            end
            S_CBOP: begin
                if (transfer) begin
                    src_d   = Fetch_Data;
                    xpt_d   = '0;
                    chain_d = 1'b0;
                    cnt_d   = '0;
                    state_d = S_EXEC;
                end
            end
`endif
            default: begin
                state_d = S_FETCH;
            end
        endcase

        freq_d = (state_d != S_EXEC);
        dec_d  = (state_d == S_EXEC);
    end

    // State and output registers; complements are registered alongside their true values
    always_ff @(posedge CLK or negedge notReset) begin
        if (!notReset) begin
            state_q <= S_FETCH;
            freq_q  <= 1'b1;
            dec_q   <= 1'b0;
            xpt_q   <= '0;
            nxpt_q  <= '1;
            src_q   <= 8'h00;
            nsrc_q  <= 8'hFF;
            xix_q   <= 1'b0;
            xiy_q   <= 1'b0;
            disp_q  <= 16'h0000;
            chain_q <= 1'b0;
            cnt_q   <= '0;
            povf_q  <= 1'b0;
            ovr_q   <= 1'b0;
`ifdef OP_PREFIX_CB_EN
            iscb_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            freq_q  <= freq_d;
            dec_q   <= dec_d;
            xpt_q   <= xpt_d;
            nxpt_q  <= ~xpt_d;
            src_q   <= src_d;
            nsrc_q  <= ~src_d;
            xix_q   <= xix_d;
            xiy_q   <= xiy_d;
            disp_q  <= disp_d;
            chain_q <= chain_d;
            cnt_q   <= cnt_d;
            povf_q  <= povf_d;
            ovr_q   <= ovr_d;
`ifdef OP_PREFIX_CB_EN
            iscb_q  <= iscb_d;
`endif
        end
    end

    assign Fetch_Req       = freq_q;
    assign Decode_Enable   = dec_q;
    assign XIX             = xix_q;
    assign XIY             = xiy_q;
    assign is_Y            = xiy_q;
    assign XPT             = xpt_q;
    assign notXPT          = nxpt_q;
    assign Source          = src_q;
    assign notSource       = nsrc_q;
    assign Disp_Ext        = disp_q;
    assign Prefix_Chain    = chain_q;
    assign Prefix_Overflow = povf_q;
    assign XPT_Overrun     = ovr_q;
`ifdef OP_PREFIX_CB_EN
    assign Is_CB           = iscb_q;
`endif

endmodule
